// File: rtl/anabellek_denetleyici.sv
// Shared single-port SRAM controller for an instruction cache (l1b) and a data cache (l1v).
// Define ANABELLEK_ROUND_ROBIN_EN for round-robin arbitration; otherwise l1v has fixed priority.
module anabellek_denetleyici #(
  parameter int BEKLEME = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [16:0] l1b_iomem_addr_i,
  input  logic        l1b_iomem_valid_i,
  output logic [31:0] l1b_iomem_rdata_o,
  output logic        l1b_iomem_ready_o,
  input  logic [16:0] l1v_iomem_addr_i,
  input  logic        l1v_iomem_valid_i,
  input  logic [31:0] l1v_iomem_wdata_i,
  input  logic [3:0]  l1v_iomem_wstrb_i,
  output logic [31:0] l1v_iomem_rdata_o,
  output logic        l1v_iomem_ready_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [16:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {BOSTA, BEKLE, ERISIM, OKU, YANIT} durum_e;

  localparam logic [3:0] BEKLE_SON = (BEKLEME == 0) ? 4'd0 : 4'(BEKLEME - 1);

  durum_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_b_q, gnt_b_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_b_q, rdata_b_d;
  logic [31:0] rdata_v_q, rdata_v_d;
  logic        pick_b;

`ifdef ANABELLEK_ROUND_ROBIN_EN
  // prio_b_q set means l1b wins the next tie, i.e. l1v was served last.
  logic prio_b_q, prio_b_d;
  assign pick_b = l1b_iomem_valid_i & (~l1v_iomem_valid_i | prio_b_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio_b_q <= 1'b0;
    else       prio_b_q <= prio_b_d;
  end
`else
  assign pick_b = ~l1v_iomem_valid_i;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_b_d = rdata_b_q;
    rdata_v_d = rdata_v_q;
`ifdef ANABELLEK_ROUND_ROBIN_EN
    prio_b_d  = prio_b_q;
`endif
    unique case (state_q)
      BOSTA: begin
        if (l1b_iomem_valid_i || l1v_iomem_valid_i) begin
          gnt_b_d = pick_b;
          addr_d  = pick_b ? l1b_iomem_addr_i : l1v_iomem_addr_i;
          wdata_d = pick_b ? 32'd0 : l1v_iomem_wdata_i;
          wstrb_d = pick_b ? 4'd0 : l1v_iomem_wstrb_i;
`ifdef ANABELLEK_ROUND_ROBIN_EN
          prio_b_d = ~pick_b;
`endif
          state_d = (BEKLEME > 0) ? BEKLE : ERISIM;
        end
      end
      BEKLE: begin
        if (cnt_q == BEKLE_SON) begin
          cnt_d   = 4'd0;
          state_d = ERISIM;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ERISIM: state_d = (wstrb_q == 4'd0) ? OKU : YANIT;
      OKU: begin
        if (gnt_b_q) rdata_b_d = mem_rdata_i;
        else         rdata_v_d = mem_rdata_i;
        state_d = YANIT;
      end
      YANIT:   state_d = BOSTA;
      default: state_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q   <= BOSTA;
      cnt_q     <= 4'd0;
      gnt_b_q   <= 1'b0;
      addr_q    <= 17'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_b_q <= 32'd0;
      rdata_v_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_b_q <= rdata_b_d;
      rdata_v_q <= rdata_v_d;
    end
  end

  assign mem_en_o          = (state_q == ERISIM);
  assign mem_we_o          = mem_en_o ? wstrb_q : 4'd0;
  assign mem_addr_o        = addr_q;
  assign mem_wdata_o       = wdata_q;
  assign l1b_iomem_ready_o = (state_q == YANIT) &  gnt_b_q;
  assign l1v_iomem_ready_o = (state_q == YANIT) & ~gnt_b_q;
  assign l1b_iomem_rdata_o = rdata_b_q;
  assign l1v_iomem_rdata_o = rdata_v_q;

endmodule
